// File: rtl/osc_dma_wr_arb_pkg.sv
// Shared types and constants for the oscilloscope DMA write arbiter.
//  state_e        : burst FSM states (idle, address, data, response)
//  AXI_BURST_INCR : AXI incrementing burst encoding
//  AXI_RESP_OKAY  : AXI OKAY response encoding
//  burst_bytes()  : bytes moved by one burst of burst_len beats of dw bits
package osc_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAw,
    StW,
    StB
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int unsigned burst_bytes(int unsigned burst_len, int unsigned dw);
    return burst_len * dw / 8;
  endfunction

endpackage

// File: rtl/osc_dma_wr_arb_if.sv
// AXI3 write-channel bundle (AW, W, B) between the arbiter and the HP port.
//  master : arbiter side, drives AW/W payload+valid and bready
//  slave  : interconnect side, drives awready, wready and the B response
interface osc_dma_wr_arb_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 32
);

  logic [AW-1:0]   awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/osc_dma_ch_ptr.sv
// Per-channel circular buffer offset tracker.
//  clk, rstn    : clock, synchronous active-low reset
//  en_i         : channel enable (rising edge requests a pointer clear)
//  in_flight_i  : a burst of this channel is outstanding
//  adv_i        : burst completed, advance offset by BB
//  size_i       : buffer size in bytes (multiple of BB)
//  offset_o     : current byte offset into the buffer
//  wrap_o       : sticky, buffer wrapped at least once
//  clr_pend_o   : clear requested but not yet applied
module osc_dma_ch_ptr #(
  parameter int unsigned AW = 32,
  parameter int unsigned BB = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  input  logic          in_flight_i,
  input  logic          adv_i,
  input  logic [AW-1:0] size_i,
  output logic [AW-1:0] offset_o,
  output logic          wrap_o,
  output logic          clr_pend_o
);

  logic [AW-1:0] offset_q, offset_d, offset_inc;
  logic          wrap_q, wrap_d;
  logic          en_prev_q;
  logic          pend_q, pend_d, pend;

  always_comb begin
    // An enable edge seen mid-burst is held until the burst retires.
    pend       = pend_q | (en_i & ~en_prev_q);
    offset_inc = offset_q + AW'(BB);
    offset_d   = offset_q;
    wrap_d     = wrap_q;
    pend_d     = pend;
    if (adv_i) begin
      if (offset_inc == size_i) begin
        offset_d = '0;
        wrap_d   = 1'b1;
      end else begin
        offset_d = offset_inc;
      end
    end else if (pend && !in_flight_i) begin
      offset_d = '0;
      wrap_d   = 1'b0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      offset_q  <= '0;
      wrap_q    <= 1'b0;
      en_prev_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      offset_q  <= offset_d;
      wrap_q    <= wrap_d;
      en_prev_q <= en_i;
      pend_q    <= pend_d;
    end
  end

  assign offset_o   = offset_q;
  assign wrap_o     = wrap_q;
  assign clr_pend_o = pend;

endmodule

// File: rtl/osc_dma_wr_arb.sv
// Two-channel burst scheduler sharing one AXI3 write master between the
// oscilloscope capture FIFOs. Grants a full burst, round-robin, to a channel
// holding at least BURST_LEN words and writes it into that channel's circular
// DDR buffer. One burst outstanding at a time.
//  clk, rstn    : clock, synchronous active-low reset
//  ch_en_i      : per-channel enable
//  cfg_base_i   : per-channel buffer base (BB aligned)
//  cfg_size_i   : per-channel buffer size in bytes (multiple of BB)
//  ch_lvl_i     : per-channel FIFO fill level
//  ch_dat_i     : per-channel FIFO head word (first-word-fall-through)
//  ch_rd_o      : per-channel FIFO pop, one per accepted W beat
//  m_axi        : AXI3 write master (AW/W/B)
//  wr_ptr_o     : per-channel next write address
//  wrap_o       : per-channel sticky wrap flag
//  err_o        : sticky, non-OKAY write response seen
//  busy_o       : burst in progress
module osc_dma_wr_arb
  import osc_dma_pkg::*;
#(
  parameter int unsigned DW        = 64,
  parameter int unsigned AW        = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned LVL_W     = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           ch_en_i,
  input  logic [1:0][AW-1:0]   cfg_base_i,
  input  logic [1:0][AW-1:0]   cfg_size_i,
  input  logic [1:0][LVL_W-1:0] ch_lvl_i,
  input  logic [1:0][DW-1:0]   ch_dat_i,
  output logic [1:0]           ch_rd_o,
  osc_dma_wr_arb_if.master     m_axi,
  output logic [1:0][AW-1:0]   wr_ptr_o,
  output logic [1:0]           wrap_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int unsigned BB     = burst_bytes(BURST_LEN, DW);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic [1:0]          elig;
  logic [1:0]          adv;
  logic [1:0]          pend;
  logic [1:0][AW-1:0]  offset;
  logic                win;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    osc_dma_ch_ptr #(
      .AW(AW),
      .BB(BB)
    ) u_ptr (
      .clk        (clk),
      .rstn       (rstn),
      .en_i       (ch_en_i[c]),
      .in_flight_i((state_q != StIdle) && (gnt_q == 1'(c))),
      .adv_i      (adv[c]),
      .size_i     (cfg_size_i[c]),
      .offset_o   (offset[c]),
      .wrap_o     (wrap_o[c]),
      .clr_pend_o (pend[c])
    );

    // A channel with a pending pointer clear waits one cycle so its burst
    // is addressed from the cleared offset.
    assign elig[c]     = ch_en_i[c] & (ch_lvl_i[c] >= LVL_W'(BURST_LEN)) & ~pend[c];
    assign wr_ptr_o[c] = cfg_base_i[c] + offset[c];
  end

  assign win = (elig == 2'b11) ? ~last_q : elig[1];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    beat_d    = beat_q;
    err_d     = err_q;
    adv       = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          gnt_d     = win;
          awaddr_d  = cfg_base_i[win] + offset[win];
          awvalid_d = 1'b1;
          state_d   = StAw;
        end
      end
      StAw: begin
        if (m_axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          state_d   = StW;
        end
      end
      StW: begin
        if (m_axi.wready) begin
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = StB;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      StB: begin
        if (m_axi.bvalid) begin
          bready_d = 1'b0;
          if (m_axi.bresp != AXI_RESP_OKAY) begin
            err_d = 1'b1;
          end
          // Pointer moves on error as well: no retry.
          adv[gnt_q] = 1'b1;
          last_d     = gnt_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      beat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = 4'(BURST_LEN - 1);
  assign m_axi.awsize  = 3'($clog2(DW / 8));
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = ch_dat_i[gnt_q];
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wvalid_q && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  assign ch_rd_o = {2{wvalid_q & m_axi.wready}} & (gnt_q ? 2'b10 : 2'b01);
  assign err_o   = err_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_osc_dma_wr_arb.sv
module tb_osc_dma_wr_arb;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned BL    = 16;
  localparam int unsigned LVL_W = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            ch_en;
  logic [1:0][AW-1:0]    base;
  logic [1:0][AW-1:0]    size;
  logic [1:0][LVL_W-1:0] lvl;
  logic [1:0][DW-1:0]    dat;
  logic [1:0]            ch_rd;
  logic [1:0][AW-1:0]    wr_ptr;
  logic [1:0]            wrap;
  logic                  err;
  logic                  busy;

  osc_dma_wr_arb_if #(.DW(DW), .AW(AW)) axi ();

  osc_dma_wr_arb #(
    .DW(DW),
    .AW(AW),
    .BURST_LEN(BL),
    .LVL_W(LVL_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ch_en_i   (ch_en),
    .cfg_base_i(base),
    .cfg_size_i(size),
    .ch_lvl_i  (lvl),
    .ch_dat_i  (dat),
    .ch_rd_o   (ch_rd),
    .m_axi     (axi),
    .wr_ptr_o  (wr_ptr),
    .wrap_o    (wrap),
    .err_o     (err),
    .busy_o    (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // FIFO model: words are tagged with channel and index so every beat is traceable.
  int pushed[2];
  int popped[2];

  function automatic logic [LVL_W-1:0] lvl_of(int p, int q);
    int d;
    d = p - q;
    if (d < 0) d = 0;
    if (d > 1023) d = 1023;
    return LVL_W'(d);
  endfunction

  assign lvl[0] = lvl_of(pushed[0], popped[0]);
  assign lvl[1] = lvl_of(pushed[1], popped[1]);
  assign dat[0] = {8'd0, 56'(popped[0])};
  assign dat[1] = {8'd1, 56'(popped[1])};

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rstn) popped[c] <= 0;
      else if (ch_rd[c]) popped[c] <= popped[c] + 1;
    end
  end

  // Scoreboard state
  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
  } aw_exp_t;
  aw_exp_t exp_q[$];

  int in_burst, cur_ch, beat, bursts_done, beats_acc;
  int exp_word[2];
  logic aw_wait;
  logic [AW-1:0] aw_hold;

  // Slave knobs
  int aw_delay = 0;
  int w_pct = 100;
  int bad_burst = -1;

  // AXI slave: responds from DUT outputs, drives 1 time unit after the edge.
  initial begin
    int aw_cnt;
    aw_cnt = 0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (axi.awvalid === 1'b1) begin
        axi.awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        axi.awready = 1'b0;
        aw_cnt = 0;
      end
      axi.wready = (axi.wvalid === 1'b1) && (int'($urandom_range(99)) < w_pct);
      if (axi.bready === 1'b1) begin
        if (!axi.bvalid) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (bursts_done == bad_burst) ? 2'b10 : 2'b00;
        end
      end else begin
        axi.bvalid = 1'b0;
      end
    end
  end

  // Monitor: checks every handshake against the expected-burst queue.
  initial begin
    aw_exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_burst = 0;
        beat = 0;
        bursts_done = 0;
        beats_acc = 0;
        exp_word[0] = 0;
        exp_word[1] = 0;
        aw_wait = 1'b0;
      end else begin
        if (axi.awvalid && aw_wait) check("aw_stable", axi.awaddr, aw_hold);
        aw_wait = axi.awvalid && !axi.awready;
        aw_hold = axi.awaddr;
        if (axi.awvalid && axi.awready) begin
          check("aw_overlap", in_burst, 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL aw_unexpected actual=%h required=none", axi.awaddr);
          end else begin
            e = exp_q.pop_front();
            check("aw_addr", axi.awaddr, e.addr);
            check("aw_ctrl", {axi.awlen, axi.awsize, axi.awburst}, {4'd15, 3'd3, 2'd1});
            cur_ch = e.ch;
          end
          in_burst = 1;
          beat = 0;
        end
        if (axi.wvalid) begin
          if (axi.wready) begin
            check("w_data", axi.wdata, {8'(cur_ch), 56'(exp_word[cur_ch])});
            check("w_last", axi.wlast, (beat == BL - 1));
            check("w_pop", ch_rd, (cur_ch == 1) ? 2'b10 : 2'b01);
            check("w_strb", axi.wstrb, 8'hff);
            exp_word[cur_ch]++;
            beat++;
            beats_acc++;
          end else begin
            check("w_nopop", ch_rd, 2'b00);
          end
        end
        if (axi.bvalid && axi.bready) begin
          check("b_beats", beat, BL);
          in_burst = 0;
          bursts_done++;
        end
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    ch_en = 2'b00;
    pushed[0] = 0;
    pushed[1] = 0;
    exp_q.delete();
    aw_delay = 0;
    w_pct = 100;
    bad_burst = -1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_bursts(input int n);
    for (int i = 0; i < 3000 && bursts_done < n; i++) @(posedge clk);
    check("bursts_done", bursts_done, n);
    @(posedge clk);
    #1;
  endtask

  task automatic exp_aw(input int ch, input logic [AW-1:0] addr);
    aw_exp_t e;
    e.ch = ch;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    base[0] = 32'h1000_0000;
    base[1] = 32'h1800_0000;
    size[0] = 32'h400;
    size[1] = 32'h400;
    ch_en = 2'b00;
    pushed[0] = 0;
    pushed[1] = 0;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_wrap", wrap, 0);
    check("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, ch_rd}, 0);
    check("rst_ptr0", wr_ptr[0], 32'h1000_0000);
    check("rst_ptr1", wr_ptr[1], 32'h1800_0000);

    // 1: single burst on ch0
    exp_aw(0, 32'h1000_0000);
    pushed[0] = 16;
    ch_en[0] = 1'b1;
    wait_bursts(1);
    check("t1_ptr0", wr_ptr[0], 32'h1000_0080);
    check("t1_wrap", wrap, 2'b00);
    check("t1_pops", popped[0], 16);
    check("t1_busy", busy, 0);

    // 2: seven more bursts wrap the 0x400 buffer; 15 words never request
    for (int k = 1; k < 8; k++) exp_aw(0, 32'h1000_0000 + 32'(k) * 32'h80);
    pushed[0] = pushed[0] + 112;
    wait_bursts(8);
    check("t2_ptr0", wr_ptr[0], 32'h1000_0000);
    check("t2_wrap", wrap, 2'b01);
    pushed[0] = pushed[0] + 15;
    repeat (40) @(posedge clk);
    #1;
    check("t2_lvl15_bursts", bursts_done, 8);
    check("t2_lvl15_busy", busy, 0);

    // 3: round robin between both channels
    do_reset();
    exp_aw(0, 32'h1000_0000);
    exp_aw(1, 32'h1800_0000);
    exp_aw(0, 32'h1000_0080);
    exp_aw(1, 32'h1800_0080);
    pushed[0] = 32;
    pushed[1] = 32;
    ch_en = 2'b11;
    wait_bursts(4);
    check("t3_ptr0", wr_ptr[0], 32'h1000_0100);
    check("t3_ptr1", wr_ptr[1], 32'h1800_0100);
    check("t3_queue", exp_q.size(), 0);

    // 4: slow awready, random wready
    do_reset();
    aw_delay = 5;
    w_pct = 50;
    exp_aw(0, 32'h1000_0000);
    pushed[0] = 16;
    ch_en[0] = 1'b1;
    wait_bursts(1);
    check("t4_pops", popped[0], 16);
    check("t4_beats", beats_acc, 16);
    check("t4_ptr0", wr_ptr[0], 32'h1000_0080);

    // 5: SLVERR on first burst, pointer still advances
    do_reset();
    bad_burst = 0;
    exp_aw(0, 32'h1000_0000);
    exp_aw(0, 32'h1000_0080);
    pushed[0] = 32;
    ch_en[0] = 1'b1;
    wait_bursts(1);
    check("t5_err", err, 1);
    check("t5_ptr0_a", wr_ptr[0], 32'h1000_0080);
    wait_bursts(2);
    check("t5_err_sticky", err, 1);
    check("t5_ptr0_b", wr_ptr[0], 32'h1000_0100);

    // 6: reset in the middle of the second burst's W phase
    do_reset();
    exp_aw(0, 32'h1000_0000);
    exp_aw(0, 32'h1000_0080);
    pushed[0] = 32;
    ch_en[0] = 1'b1;
    wait_bursts(1);
    check("t6_ptr0_pre", wr_ptr[0], 32'h1000_0080);
    for (int i = 0; i < 500 && !(in_burst != 0 && beat >= 7); i++) begin
      @(posedge clk);
      #1;
    end
    check("t6_beat7", beat, 7);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_valids", {axi.awvalid, axi.wvalid, axi.bready, ch_rd}, 0);
    check("t6_busy", busy, 0);
    check("t6_ptr0", wr_ptr[0], 32'h1000_0000);
    check("t6_wrap", wrap, 2'b00);
    rstn = 1'b1;
    ch_en = 2'b00;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
